// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin arbiter that shares one multiplier among NREQ
// requesters. Each grant runs one operation: latch the winner's operands,
// pulse mult_start, wait for mult_valid, then return the result with a
// one-cycle rsp_valid pulse to the winner.
//
// Optional build macro: MULT_ARB_TIMEOUT_EN bounds the WAIT state to TIMEOUT
// cycles. On timeout the requester gets rsp_result = 0 and rsp_err = 1.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no operation; arbitrate when any req is high and multiplier free
// ISSUE | operands latched, mult_start high for this one cycle
// WAIT  | waiting for mult_valid (or, optionally, for the timeout)
// RESP  | rsp_valid pulse to the granted requester; round-robin pointer moves
module mult_arbiter #(
  parameter int WIDTH   = 24,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_rs1,
  input  logic [NREQ*WIDTH-1:0] req_rs2,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_result,
  output logic                  rsp_err,
  output logic                  mult_start,
  output logic [WIDTH-1:0]      mult_rs1,
  output logic [WIDTH-1:0]      mult_rs2,
  input  logic [WIDTH-1:0]      mult_result,
  input  logic                  mult_valid,
  input  logic                  mult_busy,
  output logic                  arb_busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]     gnt_idx_q, gnt_idx_d;
  logic [IW-1:0]     last_q, last_d;
  logic [WIDTH-1:0]  rs1_q, rs1_d;
  logic [WIDTH-1:0]  rs2_q, rs2_d;
  logic              start_q, start_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]  result_q, result_d;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;
`endif

  logic              win_found;
  logic [IW-1:0]     win_idx;
  logic [IW-1:0]     cand;
  logic [WIDTH-1:0]  win_rs1;
  logic [WIDTH-1:0]  win_rs2;

  // Round-robin search: first requesting index after the last one served.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int o = 1; o <= NREQ; o++) begin
      cand = IW'((int'(last_q) + o) % NREQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Operand mux for the arbitration winner.
  always_comb begin
    win_rs1 = '0;
    win_rs2 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IW'(i)) begin
        win_rs1 = req_rs1[i*WIDTH +: WIDTH];
        win_rs2 = req_rs2[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state and registered-output logic of the sequencing FSM.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    last_d      = last_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    start_d     = 1'b0;
    rsp_valid_d = '0;
    result_d    = result_q;
`ifdef MULT_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_found && !mult_busy) begin
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          gnt_idx_d      = win_idx;
          rs1_d          = win_rs1;
          rs2_d          = win_rs2;
          start_d        = 1'b1;
          state_d        = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef MULT_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        if (mult_valid) begin
          result_d    = mult_result;
          rsp_valid_d = gnt_q;
          state_d     = S_RESP;
`ifdef MULT_ARB_TIMEOUT_EN
          err_d       = 1'b0;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // The TIMEOUT-th WAIT cycle passed without a result.
          result_d    = '0;
          err_d       = 1'b1;
          rsp_valid_d = gnt_q;
          state_d     = S_RESP;
        end else begin
          cnt_d       = cnt_q + 1'b1;
`endif
        end
      end
      S_RESP: begin
        last_d  = gnt_idx_q;
        gnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and output registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      last_q      <= IW'(NREQ - 1);
      rs1_q       <= '0;
      rs2_q       <= '0;
      start_q     <= 1'b0;
      rsp_valid_q <= '0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      last_q      <= last_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      start_q     <= start_d;
      rsp_valid_q <= rsp_valid_d;
      result_q    <= result_d;
    end
  end

`ifdef MULT_ARB_TIMEOUT_EN
  // Timeout counter and error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign rsp_err = err_q;
`else
  // No timeout hardware in this build; the expression folds to constant 0
  // and only keeps TIMEOUT referenced.
  assign rsp_err = (TIMEOUT < 0);
`endif

  assign gnt        = gnt_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = result_q;
  assign mult_start = start_q;
  assign mult_rs1   = rs1_q;
  assign mult_rs2   = rs2_q;
  assign arb_busy   = (state_q != S_IDLE);

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
- REQ-001 The block SHALL have parameter WIDTH, default 24: operand and result width in bits.
- REQ-002 The block SHALL have parameter NREQ, default 4: number of requesters (2..8).
- REQ-003 The block SHALL have parameter TIMEOUT, default 64: maximum WAIT cycles, used only under MULT_ARB_TIMEOUT_EN.
- REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
- REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
- REQ-006 The block SHALL have port req, input, NREQ bits: per-requester request level.
- REQ-007 The block SHALL have port req_rs1, input, NREQ*WIDTH bits: operand A of requester i, in slice i.
- REQ-008 The block SHALL have port req_rs2, input, NREQ*WIDTH bits: operand B of requester i, in slice i.
- REQ-009 The block SHALL have port gnt, output, NREQ bits: one-hot grant, or all zero.
- REQ-010 The block SHALL have port rsp_valid, output, NREQ bits: one-cycle result pulse to the granted requester.
- REQ-011 The block SHALL have port rsp_result, output, WIDTH bits: shared result bus.
- REQ-012 The block SHALL have port rsp_err, output, 1 bit: timeout flag, qualified by rsp_valid.
- REQ-013 The block SHALL have the multiplier-side ports mult_start (output, 1), mult_rs1 (output, WIDTH), mult_rs2 (output, WIDTH), mult_result (input, WIDTH), mult_valid (input, 1) and mult_busy (input, 1).
- REQ-014 The block SHALL have port arb_busy, output, 1 bit: high in every state except IDLE.

Function
- REQ-015 The FSM SHALL have four states: IDLE, ISSUE, WAIT and RESP.
- REQ-016 In IDLE, when any req bit is high and mult_busy is low, the FSM SHALL register gnt, latch the winner's operands into mult_rs1/mult_rs2, and go to ISSUE.
- REQ-017 Arbitration SHALL be round-robin: search starts at index last+1 modulo NREQ; last resets to NREQ-1, so requester 0 wins first.
- REQ-018 In ISSUE, mult_start SHALL be high for exactly one cycle, and the FSM SHALL then go to WAIT.
- REQ-019 mult_rs1 and mult_rs2 SHALL remain stable from ISSUE through RESP.
- REQ-020 In WAIT, on a cycle where mult_valid is sampled high, the FSM SHALL capture mult_result into rsp_result and go to RESP.
- REQ-021 In RESP, rsp_valid[g] SHALL be high for one cycle, where g is the granted index.
- REQ-022 On leaving RESP, last SHALL be set to g, gnt SHALL clear, and the FSM SHALL return to IDLE.
- REQ-023 Minimum latency SHALL be: req sampled at edge k; rsp_valid high in cycle (k + 3 + multiplier latency).
- REQ-024 A requester SHALL hold req and its operands until its rsp_valid pulse.
- REQ-025 If the granted requester drops req after grant, the operation SHALL still complete and rsp_valid SHALL still pulse.
- REQ-026 A requester that keeps req high after its rsp_valid pulse SHALL NOT be re-granted while any other req bit is high.
- REQ-027 mult_valid sampled outside WAIT SHALL be ignored.
- REQ-028 rsp_result SHALL hold its value until the next capture.
- REQ-029 gnt SHALL never have more than one bit set.
- REQ-030 At most one operation SHALL be outstanding at any time.

Reset
- REQ-031 rst SHALL force, immediately: state to IDLE, gnt to 0, rsp_valid to 0, rsp_result to 0, rsp_err to 0, mult_start to 0, mult_rs1 and mult_rs2 to 0, last to NREQ-1, and the timeout counter to 0.
- REQ-032 Reset mid-operation SHALL abandon the operation with no rsp_valid pulse.
- REQ-033 After reset, the first grant SHALL wait for mult_busy to be low.

Configuration
- REQ-034 With MULT_ARB_TIMEOUT_EN defined, a counter SHALL clear on entry to WAIT and increment each WAIT cycle.
- REQ-035 With MULT_ARB_TIMEOUT_EN defined, if the counter reaches TIMEOUT without mult_valid, the FSM SHALL go to RESP with rsp_result = 0 and rsp_err = 1 during the rsp_valid pulse.
- REQ-036 Without MULT_ARB_TIMEOUT_EN, WAIT SHALL be unbounded, rsp_err SHALL be tied to 0, and no counter logic SHALL exist.

Verification
- REQ-037 Single request: req=4'b0001, rs1=3, rs2=5, multiplier latency 4 -> gnt=0001, exactly one mult_start pulse, rsp_valid=0001 with rsp_result=15 at k+7.
- REQ-038 Contention: req=4'b1111 held, from reset -> grant order 0,1,2,3,0, with one rsp_valid per grant and gnt never multi-hot.
- REQ-039 Fairness: req0 held high and req2 pulsed in -> requester 2 is served before requester 0 is served a second time.
- REQ-040 Busy hold-off: mult_busy=1 in IDLE while req=0010 -> no grant until mult_busy falls; grant one cycle after.
- REQ-041 Reset mid-WAIT: assert rst while in WAIT -> all outputs 0 immediately and no rsp_valid pulse; the next request completes normally.
- REQ-042 Timeout (MULT_ARB_TIMEOUT_EN, TIMEOUT=8): mult_valid never asserted -> rsp_valid pulse with rsp_err=1 and rsp_result=0 after 8 WAIT cycles, then return to IDLE.
